// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants, source encoding and output-stage state type for mux_arbiter.
package mux_arb_pkg;
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;
    typedef enum logic {ST_EMPTY, ST_FULL} state_t;
endpackage

// File: rtl/mux_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way picker; ties go to the side named by prio_b.
module rr_pick2
    import mux_arb_pkg::*;
(
    input  logic a_valid_i,
    input  logic b_valid_i,
    input  logic prio_b_i,
    input  logic en_i,
    output logic grant_a_o,
    output logic grant_b_o,
    output logic grant_src_o
);
    always_comb begin
        grant_a_o   = en_i & a_valid_i & (~b_valid_i | ~prio_b_i);
        grant_b_o   = en_i & b_valid_i & (~a_valid_i | prio_b_i);
        grant_src_o = grant_b_o ? SRC_B : SRC_A;
    end
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin 2:1 arbiter feeding a one-entry registered output stage.
// Optional saturating grant counters when MUX_ARB_STATS_EN is defined.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             sel
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt_a,
    output logic [CNT_W-1:0] grant_cnt_b
`endif
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_data_q, y_data_d;
    logic             sel_q, sel_d;
    logic             prio_b_q, prio_b_d;
    logic             load_ok, grant_a, grant_b, grant_src, grant;

    // Readies are held low during reset so nothing is accepted and then discarded.
    assign load_ok = rst_n & ((state_q == ST_EMPTY) | y_ready);

    rr_pick2 u_pick (
        .a_valid_i   (a_valid),
        .b_valid_i   (b_valid),
        .prio_b_i    (prio_b_q),
        .en_i        (load_ok),
        .grant_a_o   (grant_a),
        .grant_b_o   (grant_b),
        .grant_src_o (grant_src)
    );

    always_comb begin
        grant    = grant_a | grant_b;
        state_d  = load_ok ? (grant ? ST_FULL : ST_EMPTY) : state_q;
        y_data_d = grant ? (grant_src == SRC_B ? b_data : a_data) : y_data_q;
        sel_d    = grant ? grant_src : sel_q;
        prio_b_d = grant ? (grant_src == SRC_A) : prio_b_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            y_data_q <= '0;
            sel_q    <= SRC_A;
            prio_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_data_q <= y_data_d;
            sel_q    <= sel_d;
            prio_b_q <= prio_b_d;
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign y_valid = state_q == ST_FULL;
    assign y_data  = y_data_q;
    assign sel     = sel_q;

`ifdef MUX_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    always_comb begin
        cnt_a_d = cnt_a_q + {{(CNT_W-1){1'b0}}, grant_a & (cnt_a_q != '1)};
        cnt_b_d = cnt_b_q + {{(CNT_W-1){1'b0}}, grant_b & (cnt_b_q != '1)};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end
    assign grant_cnt_a = cnt_a_q;
    assign grant_cnt_b = cnt_b_q;
`else
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed and random stimulus against a last-granted reference model.
module tb_mux_arbiter;
    localparam int W = 32;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0, y_ready = 1'b0;
    logic [W-1:0]  a_data = '0, b_data = '0;
    logic          a_ready, b_ready, y_valid, sel;
    logic [W-1:0]  y_data;
`ifdef MUX_ARB_STATS_EN
    logic [CW-1:0] grant_cnt_a, grant_cnt_b;
`endif

    mux_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
        .sel(sel)
`ifdef MUX_ARB_STATS_EN
        , .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // Reference model: the output word, where it came from, who won last, and grant totals.
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    logic         m_sel = 1'b0;
    logic         m_last_b = 1'b1;
    int           m_cnt_a = 0, m_cnt_b = 0;
    logic         e_ga, e_gb;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic room;
        #1;
        room = rst_n && (!m_valid || y_ready);
        e_ga = room && a_valid && (!b_valid || m_last_b);
        e_gb = room && b_valid && (!a_valid || !m_last_b);
        chk("a_ready", {31'b0, a_ready}, {31'b0, e_ga});
        chk("b_ready", {31'b0, b_ready}, {31'b0, e_gb});
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_data = '0; m_sel = 0; m_last_b = 1; m_cnt_a = 0; m_cnt_b = 0;
        end else if (e_ga || e_gb) begin
            m_valid = 1; m_data = e_ga ? a_data : b_data; m_sel = e_gb; m_last_b = e_gb;
            if (e_ga && m_cnt_a < SAT) m_cnt_a++;
            if (e_gb && m_cnt_b < SAT) m_cnt_b++;
        end else if (y_ready) begin
            m_valid = 0;
        end
        #1;
        chk("y_valid", {31'b0, y_valid}, {31'b0, m_valid});
        chk("y_data", y_data, m_data);
        chk("sel", {31'b0, sel}, {31'b0, m_sel});
`ifdef MUX_ARB_STATS_EN
        chk("cnt_a", {28'b0, grant_cnt_a}, m_cnt_a[W-1:0]);
        chk("cnt_b", {28'b0, grant_cnt_b}, m_cnt_b[W-1:0]);
`endif
    endtask

    task automatic drive(input logic r, input logic av, input logic bv, input logic yr);
        rst_n = r; a_valid = av; b_valid = bv; y_ready = yr;
    endtask

    initial begin
        logic [W-1:0] hold;
        a_data = 32'hA5A5A5A5; b_data = 32'h5A5A5A5A;
        // Reset with A requesting
        drive(0, 1, 0, 1);
        cycle(); cycle();
        chk("rst_a_ready", {31'b0, a_ready}, 32'd0);
        chk("rst_y_data", y_data, 32'd0);
        drive(1, 1, 0, 1);
        cycle();
        chk("first_word", y_data, 32'hA5A5A5A5);
        // Fresh priority, then contention
        drive(0, 0, 0, 1); cycle();
        drive(1, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_sel", {31'b0, sel}, i[W-1:0] & 32'd1);
            chk("rr_data", y_data, (i % 2) ? 32'h5A5A5A5A : 32'hA5A5A5A5);
        end
        // Backpressure with B waiting
        drive(1, 0, 1, 0); b_data = 32'h0BADF00D;
        hold = y_data;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold", y_data, hold);
        end
        drive(1, 0, 1, 1);
        cycle();
        chk("bp_load", y_data, 32'h0BADF00D);
        // Drain
        drive(1, 0, 0, 1);
        cycle();
        chk("drain_valid", {31'b0, y_valid}, 32'd0);
        chk("drain_data", y_data, 32'h0BADF00D);
        chk("drain_sel", {31'b0, sel}, 32'd1);
        // Reset mid-operation
        a_data = 32'hFFFFFFFF;
        drive(1, 1, 0, 0); cycle();
        chk("full_ff", y_data, 32'hFFFFFFFF);
        drive(0, 1, 0, 0); cycle();
        chk("mid_rst_data", y_data, 32'd0);
        a_data = 32'h11111111; b_data = 32'h22222222;
        drive(1, 1, 1, 1); cycle();
        chk("tie_after_rst", {31'b0, sel}, 32'd0);
        // Random traffic
        for (int i = 0; i < 300; i++) begin
            a_data = $urandom; b_data = $urandom;
            drive(($urandom_range(0, 39) != 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
            cycle();
        end
        // Saturation of A's counter
        drive(0, 0, 0, 1); cycle();
        for (int i = 0; i < 20; i++) begin
            a_data = i;
            drive(1, 1, 0, 1);
            cycle();
        end
`ifdef MUX_ARB_STATS_EN
        chk("sat_cnt_a", {28'b0, grant_cnt_a}, 32'd15);
        chk("sat_cnt_b", {28'b0, grant_cnt_b}, 32'd0);
`endif
        chk("sat_last", y_data, 32'd19);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester round-robin arbiter that owns the shared 32-bit 2:1 datapath mux. Each source offers words over a valid/ready handshake. The arbiter grants one source per cycle, drives the mux select, and registers the selected word into a one-entry output stage with its own valid/ready handshake toward the consumer. It sits between the register-file/ALU result sources and the shared result bus of the CPU.

## Interface
- WIDTH, 32, data width of both sources and the output
- CNT_W, 16, width of the grant counters (only used when MUX_ARB_STATS_EN is defined)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- a_valid  in  1  source A has a word
- a_data  in  WIDTH  source A word
- a_ready  out  1  source A word accepted this cycle
- b_valid  in  1  source B has a word
- b_data  in  WIDTH  source B word
- b_ready  out  1  source B word accepted this cycle
- y_valid  out  1  output register holds a word
- y_data  out  WIDTH  output word
- y_ready  in  1  consumer takes the word this cycle
- sel  out  1  source of the word in y_data (0 = A, 1 = B), registered
- grant_cnt_a  out  CNT_W  accepted-word count for A (MUX_ARB_STATS_EN only)
- grant_cnt_b  out  CNT_W  accepted-word count for B (MUX_ARB_STATS_EN only)

## Operation
- States: EMPTY (y_valid=0) and FULL (y_valid=1).
- load_ok = EMPTY, or FULL with y_ready=1.
- Pick rules, evaluated only when load_ok:
  - only a_valid → grant A
  - only b_valid → grant B
  - both valid → grant the side named by internal priority bit prio_b (0 → A, 1 → B)
  - neither valid → no grant
- a_ready = load_ok & grant A. b_ready = load_ok & grant B. At most one ready is high in any cycle.
- On a grant:
  - y_data ← selected data
  - sel ← granted source
  - prio_b ← (granted == A), so priority moves to the other side
  - next state FULL
- FULL with y_ready=1 and no grant → EMPTY. y_data and sel hold their last values.
- FULL with y_ready=0 → hold. Both readies stay low and y_data is stable.
- prio_b changes only on a grant, including single-requester grants.
- Reset (rst_n=0 at a clock edge) discards any held word, regardless of state.

## Timing
- Reset values:
  - y_valid=0, y_data=0, sel=0, prio_b=0 (the first tie goes to A)
  - grant counters = 0
- a_ready and b_ready are combinational from a_valid, b_valid, y_ready and state. They never depend on the data inputs.
- Latency: a word accepted in cycle N appears on y_data with y_valid=1 in cycle N+1.
- Throughput: one word per cycle while y_ready stays high. A simultaneous drain and load leaves no bubble.
- Under continuous contention with y_ready=1, grants alternate A, B, A, B, …
- A source that deasserts valid before being granted is simply not considered. The arbiter adds no source-side holding requirement.

## Configuration
- MUX_ARB_STATS_EN defined:
  - grant_cnt_a and grant_cnt_b exist.
  - Each counter increments by 1 in every cycle its ready and valid are both high.
  - Counters saturate at 2^CNT_W−1; they never wrap.
  - Counters clear only on reset.
- MUX_ARB_STATS_EN undefined: the counter ports and their logic are absent. All other behaviour is identical.

## Structure
- Package mux_arb_pkg contains:
  - SRC_A=1'b0 and SRC_B=1'b1
  - state enum {ST_EMPTY, ST_FULL}
  - default WIDTH and CNT_W constants
- One sub-module, rr_pick2: combinational picker.
  - inputs: two valids, prio_b, enable
  - outputs: grant_a, grant_b, grant_src
- The output register, state and counters live in mux_arbiter.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with a_valid=1 → a_ready=0, y_valid=0, y_data=0, sel=0. Release with a_data=32'hA5A5A5A5 → next cycle y_data=32'hA5A5A5A5, sel=0.
- Contention: a_valid=b_valid=1 for 4 cycles, a_data=32'hA5A5A5A5, b_data=32'h5A5A5A5A, y_ready=1 → sel sequence 0,1,0,1 and y_data alternates between the two words.
- Backpressure: y_ready=0 while FULL with b_valid=1 → b_ready=0 and y_data stable for 3 cycles. Raising y_ready → B's word is loaded in that same cycle with no bubble.
- Drain: FULL, y_ready=1, no valids → y_valid=0 next cycle; y_data and sel hold their last values.
- Reset mid-operation: FULL holding 32'hFFFFFFFF, rst_n=0 for one cycle → y_valid=0, y_data=0, and the next tie grants A.
- Stats (MUX_ARB_STATS_EN, CNT_W=4): 20 accepted A words → grant_cnt_a=15 (saturated), grant_cnt_b=0.
